uart_frame_parser: RTL and testbench

Byte-level packet parser sitting directly downstream of the UART receiver. Consumes one received byte per `rx_done` pulse and recognises frames of the form `HDR0 HDR1 CMD LEN PAYLOAD[LEN] SUM`. Verifies an 8-bit additive checksum and buffers the payload. Presents the command, length and payload (via a read port) to the command decoder, with one-cycle valid/error pulses. `sys_clk` is 50 MHz.

---
 rtl/uart_frame_parser.sv | 200 ++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Byte-level frame parser for the UART receive path.
// Recognises HDR0 HDR1 CMD LEN PAYLOAD[LEN] SUM and checks the 8-bit additive SUM.
// The payload goes into a single buffer, and a registered read port exposes it.
// Any byte, or the inter-byte timeout, can advance the FSM.
module uart_frame_parser #(
   parameter int          MAX_LEN      = 16,
   parameter logic [7:0]  HDR0         = 8'hAA,
   parameter logic [7:0]  HDR1         = 8'h55,
   parameter int          TIMEOUT_CLKS = 50_000,
   localparam int         AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_done,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic [7:0]    cmd,
   output logic [7:0]    len,
   output logic          frame_vld,
   output logic          frame_err,
   output logic          busy
);

   localparam int         TW       = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
   localparam logic [7:0] LEN_MAX8 = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S0_HDR0,
      S1_HDR1,
      S2_CMD,
      S3_LEN,
      S4_PLD,
      S5_SUM
   } state_t;

   state_t        state_reg,   state_next;
   logic [7:0]    cmd_tmp_reg, cmd_tmp_next;
   logic [7:0]    len_tmp_reg, len_tmp_next;
   logic [7:0]    sum_reg,     sum_next;
   logic [7:0]    idx_reg,     idx_next;
   logic [7:0]    cmd_reg,     cmd_next;
   logic [7:0]    len_reg,     len_next;
   logic          vld_reg,     vld_next;
   logic          err_reg,     err_next;
   logic [TW-1:0] tmo_reg,     tmo_next;
   logic [7:0]    rd_data_reg;
   logic          mem_we;
   logic          tmo_hit;

   logic [7:0]    pld_mem [MAX_LEN];

   // A timeout counts only while inside a frame, and only when no byte arrives that cycle.
   assign tmo_hit = (state_reg != S0_HDR0) && !rx_done && (tmo_reg == TMO_LAST);

   // State and datapath registers. Reset clears everything immediately.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg   <= S0_HDR0;
         cmd_tmp_reg <= '0;
         len_tmp_reg <= '0;
         sum_reg     <= '0;
         idx_reg     <= '0;
         cmd_reg     <= '0;
         len_reg     <= '0;
         vld_reg     <= 1'b0;
         err_reg     <= 1'b0;
         tmo_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         cmd_tmp_reg <= cmd_tmp_next;
         len_tmp_reg <= len_tmp_next;
         sum_reg     <= sum_next;
         idx_reg     <= idx_next;
         cmd_reg     <= cmd_next;
         len_reg     <= len_next;
         vld_reg     <= vld_next;
         err_reg     <= err_next;
         tmo_reg     <= tmo_next;
      end
   end

   // Next-state logic. A byte is processed first; the timeout applies only when no byte arrives.
   always_comb begin
      state_next   = state_reg;
      cmd_tmp_next = cmd_tmp_reg;
      len_tmp_next = len_tmp_reg;
      sum_next     = sum_reg;
      idx_next     = idx_reg;
      cmd_next     = cmd_reg;
      len_next     = len_reg;
      vld_next     = 1'b0;
      err_next     = 1'b0;
      mem_we       = 1'b0;
      if (rx_done || (state_reg == S0_HDR0)) begin
         tmo_next = '0;
      end else begin
         tmo_next = tmo_reg + TW'(1);
      end

      if (rx_done) begin
         case (state_reg)
            S0_HDR0: begin
               if (rx_data == HDR0) begin
                  state_next = S1_HDR1;
               end
            end
            S1_HDR1: begin
               if (rx_data == HDR1) begin
                  state_next = S2_CMD;
               end else if (rx_data != HDR0) begin
                  state_next = S0_HDR0;
               end
            end
            S2_CMD: begin
               cmd_tmp_next = rx_data;
               sum_next     = rx_data;
               state_next   = S3_LEN;
            end
            S3_LEN: begin
               if (rx_data > LEN_MAX8) begin
                  err_next   = 1'b1;
                  state_next = S0_HDR0;
               end else begin
                  len_tmp_next = rx_data;
                  sum_next     = sum_reg + rx_data;
                  idx_next     = '0;
                  state_next   = (rx_data == 8'd0) ? S5_SUM : S4_PLD;
               end
            end
            S4_PLD: begin
               mem_we   = 1'b1;
               sum_next = sum_reg + rx_data;
               idx_next = idx_reg + 8'd1;
               if (idx_reg == len_tmp_reg - 8'd1) begin
                  state_next = S5_SUM;
               end
            end
            S5_SUM: begin
               if (rx_data == sum_reg) begin
                  cmd_next = cmd_tmp_reg;
                  len_next = len_tmp_reg;
                  vld_next = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
               state_next = S0_HDR0;
            end
            default: state_next = S0_HDR0;
         endcase
      end else if (tmo_hit) begin
         err_next   = 1'b1;
         state_next = S0_HDR0;
         tmo_next   = '0;
      end
   end

   // Payload buffer, written in place. Its contents are cleared by reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            pld_mem[i] <= '0;
         end
      end else if (mem_we) begin
         pld_mem[idx_reg[AW-1:0]] <= rx_data;
      end
   end

   // Registered read port. Out-of-range addresses return 0; the range check is only needed when the depth is not a power of two.
   if (MAX_LEN == (1 << AW)) begin : g_rd_full
      // Every address is in range.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            rd_data_reg <= '0;
         end else begin
            rd_data_reg <= pld_mem[rd_addr];
         end
      end
   end else begin : g_rd_part
      // Addresses at or beyond MAX_LEN read as zero.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            rd_data_reg <= '0;
         end else if (32'(rd_addr) < MAX_LEN) begin
            rd_data_reg <= pld_mem[rd_addr];
         end else begin
            rd_data_reg <= '0;
         end
      end
   end

   assign rd_data   = rd_data_reg;
   assign cmd       = cmd_reg;
   assign len       = len_reg;
   assign frame_vld = vld_reg;
   assign frame_err = err_reg;
   assign busy      = (state_reg != S0_HDR0);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed testbench for uart_frame_parser. Each step feeds a byte sequence and checks the pulses, cmd/len and the buffer read port.
`timescale 1ns/1ps
module tb_uart_frame_parser;

   localparam int TC = 100;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic [3:0] rd_addr = 4'd0;
   logic [7:0] rd_data;
   logic [7:0] cmd;
   logic [7:0] len;
   logic       frame_vld;
   logic       frame_err;
   logic       busy;

   int tests_run = 0;
   int tests_failed = 0;
   int vld_cnt = 0;
   int err_cnt = 0;
   int vbase;
   int ebase;

   uart_frame_parser #(
      .MAX_LEN      (16),
      .HDR0         (8'hAA),
      .HDR1         (8'h55),
      .TIMEOUT_CLKS (TC)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .cmd       (cmd),
      .len       (len),
      .frame_vld (frame_vld),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #10 sys_clk = ~sys_clk;

   // Count the pulses between clock edges.
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         vld_cnt <= vld_cnt + int'(frame_vld);
         err_cnt <= err_cnt + int'(frame_err);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Send n bytes on back-to-back cycles, most significant byte first.
   task automatic feed(input int n, input logic [63:0] bytes);
      for (int i = 0; i < n; i++) begin
         rx_data = bytes[8*(n-1-i) +: 8];
         rx_done = 1'b1;
         tick();
      end
      rx_done = 1'b0;
      rx_data = 8'h00;
   endtask

   // Run just after the edge that samples the last byte. Checks the one-cycle pulse, cmd/len and busy.
   task automatic check_end(input string tag, input logic ev, input logic ee,
                            input logic [7:0] ec, input logic [7:0] el);
      check({tag, "_vld"}, frame_vld, ev);
      check({tag, "_err"}, frame_err, ee);
      check({tag, "_cmd"}, cmd, ec);
      check({tag, "_len"}, len, el);
      check({tag, "_busy"}, busy, 0);
      tick();
      check({tag, "_pulse_gone"}, {frame_vld, frame_err}, 0);
      check({tag, "_nvld"}, vld_cnt - vbase, ev);
      check({tag, "_nerr"}, err_cnt - ebase, ee);
   endtask

   task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
      rd_addr = a;
      tick();
      check(tag, rd_data, exp);
   endtask

   task automatic mark();
      vbase = vld_cnt;
      ebase = err_cnt;
   endtask

   initial begin
      // Reset state.
      repeat (3) tick();
      check("rst_outputs", {cmd, len, rd_data, 5'b0, frame_vld, frame_err, busy}, 0);
      sys_rst_n = 1'b1;
      tick();
      check("rst_busy", busy, 0);

      // Good frame.
      mark();
      feed(8, 64'hAA55010310203064);
      check_end("good", 1, 0, 8'h01, 8'h03);
      rd_check("good_rd0", 4'd0, 8'h10);
      rd_check("good_rd1", 4'd1, 8'h20);
      rd_check("good_rd2", 4'd2, 8'h30);

      // Bad checksum: cmd/len keep their previous values.
      mark();
      feed(6, 64'hAA5502010509);
      check_end("badsum", 0, 1, 8'h01, 8'h03);

      // Zero-length frame.
      mark();
      feed(5, 64'hAA55070007);
      check_end("zlen", 1, 0, 8'h07, 8'h00);

      // LEN above MAX_LEN: the error appears right after the LEN byte.
      mark();
      feed(4, 64'hAA550211);
      check_end("toolong", 0, 1, 8'h07, 8'h00);

      mark();
      feed(8, 64'hAA55010310203064);
      check_end("after_long", 1, 0, 8'h01, 8'h03);
      rd_check("after_long_rd2", 4'd2, 8'h30);

      // Resync through noise and a repeated HDR0.
      mark();
      feed(8, 64'h00AAAA550501999F);
      check_end("resync", 1, 0, 8'h05, 8'h01);
      rd_check("resync_rd0", 4'd0, 8'h99);

      // Timeout after CMD.
      mark();
      feed(3, 64'hAA5501);
      check("tmo_busy_in", busy, 1);
      repeat (TC - 1) tick();
      check("tmo_before", {frame_err, busy}, 2'b01);
      tick();
      check("tmo_fire", {frame_err, busy}, 2'b10);
      tick();
      check("tmo_gone", frame_err, 0);
      check("tmo_nerr", err_cnt - ebase, 1);

      // The next byte arrives exactly on the timeout cycle, so the frame completes.
      mark();
      feed(3, 64'hAA5501);
      repeat (TC - 1) tick();
      feed(5, 64'h0310203064);
      check_end("tmo_edge", 1, 0, 8'h01, 8'h03);

      // Reset in the middle of the payload.
      feed(5, 64'hAA55010310);
      check("mid_busy", busy, 1);
      sys_rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", {cmd, len, rd_data, 5'b0, frame_vld, frame_err, busy}, 0);
      tick();
      sys_rst_n = 1'b1;
      tick();
      rd_check("mid_rst_buf0", 4'd0, 8'h00);
      mark();
      feed(8, 64'hAA55010310203064);
      check_end("post_rst", 1, 0, 8'h01, 8'h03);
      rd_check("post_rst_rd1", 4'd1, 8'h20);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
